// File: rtl/display_timing_gen.sv
// Raster timing generator: pixel/line counters, syncs, data enable and frame pulses from shadowed timing.
// Latency: enable rise sampled at edge N -> pixel (0,0) presented in cycle N+2; every output is a flop.
// No backpressure: free-running once started; new timing is taken only at frame boundaries.
module display_timing_gen #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 disp_enable,
    input  logic [CNT_WIDTH-1:0] h_total,
    input  logic [CNT_WIDTH-1:0] h_active,
    input  logic [CNT_WIDTH-1:0] h_sync_start,
    input  logic [CNT_WIDTH-1:0] h_sync_end,
    input  logic [CNT_WIDTH-1:0] v_total,
    input  logic [CNT_WIDTH-1:0] v_active,
    input  logic [CNT_WIDTH-1:0] v_sync_start,
    input  logic [CNT_WIDTH-1:0] v_sync_end,
    input  logic [1:0]           sync_pol,
    output logic [CNT_WIDTH-1:0] h_cnt,
    output logic [CNT_WIDTH-1:0] v_cnt,
    output logic                 de,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 frame_start,
    output logic                 line_start,
    output logic                 int_frame_done,
    output logic                 int_vsync_edge,
    output logic                 running,
    output logic                 cfg_err
);

    typedef struct packed {
        logic [CNT_WIDTH-1:0] total;
        logic [CNT_WIDTH-1:0] active;
        logic [CNT_WIDTH-1:0] sync_start;
        logic [CNT_WIDTH-1:0] sync_end;
    } axis_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // One axis is usable when the active region is non-empty and the sync pulse sits inside the blanking.
    function automatic logic axis_ok(input axis_t a);
        return (a.active != '0) && (a.active <= a.sync_start) &&
               (a.sync_start < a.sync_end) && (a.sync_end <= a.total);
    endfunction

    state_t                 state_q, state_d;
    logic                   en_prev_q;
    axis_t                  sh_h_q, sh_h_d, sh_v_q, sh_v_d;
    logic [1:0]             sh_pol_q, sh_pol_d;
    logic [CNT_WIDTH-1:0]   h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic                   de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic                   frame_start_q, frame_start_d, line_start_q, line_start_d;
    logic                   frame_done_q, frame_done_d, vsync_edge_q, vsync_edge_d;
    logic                   running_q, running_d, cfg_err_q, cfg_err_d;

    axis_t                  in_h, in_v;
    logic                   cfg_ok, en_rise, h_last, v_last, at_end, load_shadow;
    logic                   hs_raw, vs_raw;

    assign in_h    = {h_total, h_active, h_sync_start, h_sync_end};
    assign in_v    = {v_total, v_active, v_sync_start, v_sync_end};
    assign cfg_ok  = axis_ok(in_h) && axis_ok(in_v);
    assign en_rise = disp_enable && !en_prev_q;
    assign h_last  = (h_cnt_q == sh_h_q.total - ONE);
    assign v_last  = (v_cnt_q == sh_v_q.total - ONE);
    assign at_end  = h_last && v_last;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start on an enable rise, leave RUN only at the last pixel of a frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en_rise) state_d = ST_CHECK;
            ST_CHECK: state_d = cfg_ok ? ST_RUN : ST_IDLE;
            ST_RUN:   if (at_end && (!disp_enable || !cfg_ok)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Shadow reload, error flag and counter advance; a reload at the boundary restarts at (0,0) with no gap.
    always_comb begin
        load_shadow = (state_q == ST_CHECK) || ((state_q == ST_RUN) && at_end && disp_enable);
        sh_h_d      = load_shadow ? in_h : sh_h_q;
        sh_v_d      = load_shadow ? in_v : sh_v_q;
        sh_pol_d    = load_shadow ? sync_pol : sh_pol_q;
        cfg_err_d   = load_shadow ? !cfg_ok : cfg_err_q;
        h_cnt_d     = '0;
        v_cnt_d     = '0;
        if ((state_q == ST_RUN) && (state_d == ST_RUN) && !at_end) begin
            if (h_last) begin
                v_cnt_d = v_cnt_q + ONE;
            end else begin
                h_cnt_d = h_cnt_q + ONE;
                v_cnt_d = v_cnt_q;
            end
        end
    end

    // Output decode on the next counter values so every output lines up with the counters it is registered with.
    always_comb begin
        running_d     = (state_d == ST_RUN);
        hs_raw        = (h_cnt_d >= sh_h_d.sync_start) && (h_cnt_d < sh_h_d.sync_end);
        vs_raw        = (v_cnt_d >= sh_v_d.sync_start) && (v_cnt_d < sh_v_d.sync_end);
        de_d          = running_d && (h_cnt_d < sh_h_d.active) && (v_cnt_d < sh_v_d.active);
        hsync_d       = (running_d && hs_raw) ^ sh_pol_d[0];
        vsync_d       = (running_d && vs_raw) ^ sh_pol_d[1];
        line_start_d  = running_d && (h_cnt_d == '0);
        frame_start_d = line_start_d && (v_cnt_d == '0);
        vsync_edge_d  = line_start_d && (v_cnt_d == sh_v_d.sync_start);
        frame_done_d  = running_d && (h_cnt_d == sh_h_d.total - ONE) &&
                        (v_cnt_d == sh_v_d.total - ONE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_prev_q     <= 1'b0;
            sh_h_q        <= '0;
            sh_v_q        <= '0;
            sh_pol_q      <= 2'b00;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            de_q          <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            vsync_edge_q  <= 1'b0;
            running_q     <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            en_prev_q     <= disp_enable;
            sh_h_q        <= sh_h_d;
            sh_v_q        <= sh_v_d;
            sh_pol_q      <= sh_pol_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
            frame_done_q  <= frame_done_d;
            vsync_edge_q  <= vsync_edge_d;
            running_q     <= running_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign h_cnt          = h_cnt_q;
    assign v_cnt          = v_cnt_q;
    assign de             = de_q;
    assign hsync          = hsync_q;
    assign vsync          = vsync_q;
    assign frame_start    = frame_start_q;
    assign line_start     = line_start_q;
    assign int_frame_done = frame_done_q;
    assign int_vsync_edge = vsync_edge_q;
    assign running        = running_q;
    assign cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: table of timing configurations with per-frame statistics,
// hand-written corner sequences, and a randomized run against a frame-position model.
// All outputs are sampled on the falling clock edge; inputs are driven right after sampling.
module tb_display_timing_gen;
    localparam int W = 16;

    typedef struct packed { int tot; int act; int ss; int se; } ax_t;
    typedef struct packed { ax_t h; ax_t v; logic [1:0] pol; } cfg_t;
    typedef struct packed { cfg_t cfg; bit err; int period; int de_n; int hs_hi; int vs_hi; } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic disp_enable;
    logic [W-1:0] h_total, h_active, h_sync_start, h_sync_end;
    logic [W-1:0] v_total, v_active, v_sync_start, v_sync_end;
    logic [1:0] sync_pol;
    logic [W-1:0] h_cnt, v_cnt;
    logic de, hsync, vsync, frame_start, line_start, int_frame_done, int_vsync_edge, running, cfg_err;
    logic [40:0] dut_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    display_timing_gen #(.CNT_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .disp_enable(disp_enable),
        .h_total(h_total), .h_active(h_active), .h_sync_start(h_sync_start), .h_sync_end(h_sync_end),
        .v_total(v_total), .v_active(v_active), .v_sync_start(v_sync_start), .v_sync_end(v_sync_end),
        .sync_pol(sync_pol), .h_cnt(h_cnt), .v_cnt(v_cnt), .de(de), .hsync(hsync), .vsync(vsync),
        .frame_start(frame_start), .line_start(line_start), .int_frame_done(int_frame_done),
        .int_vsync_edge(int_vsync_edge), .running(running), .cfg_err(cfg_err)
    );

    assign dut_vec = {h_cnt, v_cnt, de, hsync, vsync, frame_start, line_start,
                      int_frame_done, int_vsync_edge, running, cfg_err};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ax_t mka(input int t, input int a, input int s, input int e);
        ax_t r;
        r.tot = t; r.act = a; r.ss = s; r.se = e;
        return r;
    endfunction

    function automatic cfg_t mkc(input ax_t h, input ax_t v, input logic [1:0] p);
        cfg_t c;
        c.h = h; c.v = v; c.pol = p;
        return c;
    endfunction

    function automatic vec_t mkv(input cfg_t c, input bit e, input int p, input int d, input int hs, input int vs);
        vec_t r;
        r.cfg = c; r.err = e; r.period = p; r.de_n = d; r.hs_hi = hs; r.vs_hi = vs;
        return r;
    endfunction

    function automatic bit ax_ok(input ax_t a);
        return (a.act >= 1) && (a.act <= a.ss) && (a.ss < a.se) && (a.se <= a.tot);
    endfunction

    task automatic apply(input cfg_t c);
        h_total = W'(c.h.tot); h_active = W'(c.h.act); h_sync_start = W'(c.h.ss); h_sync_end = W'(c.h.se);
        v_total = W'(c.v.tot); v_active = W'(c.v.act); v_sync_start = W'(c.v.ss); v_sync_end = W'(c.v.se);
        sync_pol = c.pol;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        disp_enable = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Enable rises now; returns at the sample of cycle N+2.
    task automatic start();
        disp_enable = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_pos(input int h, input int v, input int budget, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (running && h_cnt == W'(h) && v_cnt == W'(v)) found = 1'b1;
            else @(negedge clk);
        end
        chk(name, 64'(found), 64'd1);
    endtask

    // Reference model: frame position derived from the cycle index within the frame.
    int   m_st, m_k;
    bit   m_enp, m_err;
    cfg_t m_sh;

    function automatic logic [40:0] model_vec();
        int h, v;
        logic dd, hs, vs, fs, ls, fd, ve, rn;
        if (m_st == 2) begin
            h  = m_k % m_sh.h.tot;
            v  = m_k / m_sh.h.tot;
            rn = 1'b1;
            dd = (h < m_sh.h.act) && (v < m_sh.v.act);
            hs = ((h >= m_sh.h.ss) && (h < m_sh.h.se)) ^ m_sh.pol[0];
            vs = ((v >= m_sh.v.ss) && (v < m_sh.v.se)) ^ m_sh.pol[1];
            fs = (m_k == 0);
            ls = (h == 0);
            fd = (m_k == m_sh.h.tot * m_sh.v.tot - 1);
            ve = (h == 0) && (v == m_sh.v.ss);
        end else begin
            h = 0; v = 0; rn = 1'b0; dd = 1'b0;
            hs = m_sh.pol[0]; vs = m_sh.pol[1];
            fs = 1'b0; ls = 1'b0; fd = 1'b0; ve = 1'b0;
        end
        return {h[W-1:0], v[W-1:0], dd, hs, vs, fs, ls, fd, ve, rn, m_err};
    endfunction

    task automatic model_step(input bit en, input cfg_t c);
        case (m_st)
            0: if (en && !m_enp) m_st = 1;
            1: begin
                m_sh = c;
                if (ax_ok(c.h) && ax_ok(c.v)) begin m_st = 2; m_k = 0; m_err = 1'b0; end
                else begin m_st = 0; m_err = 1'b1; end
            end
            default: begin
                if (m_k == m_sh.h.tot * m_sh.v.tot - 1) begin
                    if (!en) m_st = 0;
                    else begin
                        m_sh = c;
                        if (ax_ok(c.h) && ax_ok(c.v)) m_k = 0;
                        else begin m_st = 0; m_err = 1'b1; end
                    end
                end else begin
                    m_k++;
                end
            end
        endcase
        m_enp = en;
    endtask

    function automatic ax_t rand_ax();
        ax_t a;
        a.tot = int'($urandom_range(2, 8));
        a.act = int'($urandom_range(1, a.tot - 1));
        a.ss  = int'($urandom_range(a.act, a.tot - 1));
        a.se  = int'($urandom_range(a.ss + 1, a.tot));
        if ($urandom_range(0, 11) == 0) a.se = a.tot + 1;
        if ($urandom_range(0, 11) == 0) a.act = 0;
        return a;
    endfunction

    cfg_t base, cur;
    vec_t tbl[7];
    int   per, de_n, hs_n, vs_n, de_seen, f, de_f0, de_f1;
    bit   in_frame, done, en, hit;

    initial begin
        base = mkc(mka(10, 6, 7, 9), mka(5, 3, 4, 5), 2'b00);
        tbl[0] = mkv(base, 1'b0, 50, 18, 10, 10);
        tbl[1] = mkv(mkc(base.h, base.v, 2'b11), 1'b0, 50, 18, 40, 40);
        tbl[2] = mkv(mkc(mka(10, 6, 7, 11), base.v, 2'b00), 1'b1, 0, 0, 0, 0);
        tbl[3] = mkv(mkc(mka(8, 4, 5, 7), mka(4, 2, 2, 3), 2'b01), 1'b0, 32, 8, 24, 8);
        tbl[4] = mkv(mkc(base.h, mka(5, 0, 4, 5), 2'b00), 1'b1, 0, 0, 0, 0);
        tbl[5] = mkv(mkc(mka(10, 6, 7, 7), base.v, 2'b00), 1'b1, 0, 0, 0, 0);
        tbl[6] = mkv(mkc(mka(6, 3, 3, 6), mka(3, 1, 1, 3), 2'b10), 1'b0, 18, 3, 9, 6);

        // Reset defaults.
        rst = 1'b1;
        disp_enable = 1'b0;
        apply(base);
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'(dut_vec), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", 64'(dut_vec), 64'd0);

        // Start latency, vsync edge and frame-done positions.
        disp_enable = 1'b1;
        @(negedge clk);
        chk("n1_running", 64'({running, frame_start}), 64'd0);
        @(negedge clk);
        chk("n2_first_pixel", 64'({running, frame_start, line_start, de, h_cnt, v_cnt}), {28'd0, 4'b1111, 32'd0});
        repeat (40) @(negedge clk);
        chk("vsync_edge_0_4", 64'({int_vsync_edge, vsync, h_cnt, v_cnt}), 64'({2'b11, 16'd0, 16'd4}));
        repeat (9) @(negedge clk);
        chk("frame_done_9_4", 64'({int_frame_done, h_cnt, v_cnt}), 64'({1'b1, 16'd9, 16'd4}));
        @(negedge clk);
        chk("frame_period_50", 64'({frame_start, h_cnt, v_cnt}), 64'({1'b1, 32'd0}));

        // Table: per-configuration single-frame statistics.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            apply(tbl[i].cfg);
            start();
            chk($sformatf("t%0d_running", i), 64'(running), 64'(!tbl[i].err));
            chk($sformatf("t%0d_cfg_err", i), 64'(cfg_err), 64'(tbl[i].err));
            per = 0; de_n = 0; hs_n = 0; vs_n = 0; de_seen = 0; in_frame = 0; done = 0;
            for (int c = 0; c < 120; c++) begin
                if (frame_start) begin
                    if (in_frame) done = 1'b1;
                    else in_frame = 1'b1;
                end
                if (in_frame && !done) begin
                    per++; de_n += int'(de); hs_n += int'(hsync); vs_n += int'(vsync);
                end
                de_seen += int'(de);
                @(negedge clk);
            end
            chk($sformatf("t%0d_period", i), 64'(per), 64'(tbl[i].period));
            chk($sformatf("t%0d_de_cycles", i), 64'(de_n), 64'(tbl[i].de_n));
            chk($sformatf("t%0d_hsync_high", i), 64'(hs_n), 64'(tbl[i].hs_hi));
            chk($sformatf("t%0d_vsync_high", i), 64'(vs_n), 64'(tbl[i].vs_hi));
            if (tbl[i].err) chk($sformatf("t%0d_de_never", i), 64'(de_seen), 64'd0);
        end

        // Invalid config, held enable does not restart, toggle recovers.
        do_reset();
        apply(tbl[2].cfg);
        start();
        chk("inv_cfg_err", 64'({cfg_err, running}), 64'b10);
        apply(base);
        repeat (10) @(negedge clk);
        chk("inv_no_restart", 64'({cfg_err, running}), 64'b10);
        disp_enable = 1'b0;
        @(negedge clk);
        start();
        chk("inv_recover", 64'({cfg_err, running}), 64'b01);

        // Shadowing: h_active change mid-frame applies from the next frame.
        do_reset();
        apply(base);
        start();
        f = -1; de_f0 = 0; de_f1 = 0;
        for (int i = 0; i < 130; i++) begin
            if (frame_start) f++;
            if (de && f == 0) de_f0++;
            if (de && f == 1) de_f1++;
            if (f == 0 && running && h_cnt == 16'd3 && v_cnt == 16'd1) h_active = 16'd4;
            @(negedge clk);
        end
        chk("shadow_cur_frame_de", 64'(de_f0), 64'd18);
        chk("shadow_next_frame_de", 64'(de_f1), 64'd12);

        // Graceful stop: frame completes, then idle.
        do_reset();
        apply(base);
        start();
        wait_pos(2, 1, 60, "stop_reach_2_1");
        disp_enable = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (int_frame_done) hit = 1'b1;
            else @(negedge clk);
        end
        chk("stop_frame_done", 64'({hit, h_cnt, v_cnt}), 64'({1'b1, 16'd9, 16'd4}));
        @(negedge clk);
        chk("stop_idle", 64'({running, h_cnt, v_cnt}), 64'd0);

        // Inverted polarity, then asynchronous reset mid-frame.
        do_reset();
        apply(mkc(base.h, base.v, 2'b11));
        start();
        wait_pos(7, 4, 60, "pol_reach_7_4");
        chk("pol_sync_low", 64'({hsync, vsync}), 64'b00);
        wait_pos(5, 2, 60, "pol_reach_5_2");
        chk("pol_sync_high", 64'({hsync, vsync}), 64'b11);
        #1 rst = 1'b1;
        #1 chk("async_reset", 64'(dut_vec), 64'd0);
        disp_enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Randomized run against the frame-position model.
        do_reset();
        m_st = 0; m_k = 0; m_enp = 1'b0; m_err = 1'b0; m_sh = '0;
        en = 1'b0;
        cur = base;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            chk("random_outputs", 64'(dut_vec), 64'(model_vec()));
            if (en) begin
                if ($urandom_range(0, 59) == 0) en = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                en = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) cur = mkc(rand_ax(), rand_ax(), 2'($urandom_range(0, 3)));
            apply(cur);
            disp_enable = en;
            model_step(en, cur);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
